// File: rtl/mop_cs_accu_pkg.sv
// Shared types and elaboration helpers for the multi-operand carry-save
// accumulator.
//   mop_state_e : controller states (ACCU, RESOLVE, OUTPUT)
//   speed_e     : carried over from the shared package; not used here
//   sum_width   : result width for a given operand width and operand count
//   num_chunks  : carry-propagate passes needed to resolve a sum
package mop_cs_accu_pkg;

  typedef enum logic [0:0] {
    SPEED_SMALL,
    SPEED_FAST
  } speed_e;

  typedef enum logic [1:0] {
    ACCU,
    RESOLVE,
    OUTPUT
  } mop_state_e;

  function automatic int unsigned sum_width(input int unsigned width,
                                            input int unsigned num_ops);
    return width + $clog2(num_ops);
  endfunction

  function automatic int unsigned num_chunks(input int unsigned sum_w,
                                             input int unsigned chunk_w);
    return (sum_w + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/mop_cs_accu_if.sv
// Operand-in / result-out handshake bundle of mop_cs_accu.
//   in_valid_i / in_ready_o / op_i    : operand stream (producer -> accumulator)
//   out_valid_o / out_ready_i / sum_o : binary result (accumulator -> consumer)
// slave  : accumulator side
// master : producer/consumer side
interface mop_cs_accu_if #(
  parameter int unsigned width = 16,
  parameter int unsigned sumW  = 19
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [width-1:0] op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [sumW-1:0]  sum_o;

  modport slave (
    input  in_valid_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o
  );

  modport master (
    output in_valid_i, op_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o
  );

endinterface

// File: rtl/mop_cs_accu_cpa.sv
// Adder primitives shared by the 3:2 row and the chunked carry-propagate stage.
//   FullAdder : 1-bit full adder; A, B, CI in; S, CO out
//   CpaChunk  : chunkWidth-bit ripple adder from FullAdder cells;
//               A, B [chunkWidth], CI in; S [chunkWidth], CO out
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

module CpaChunk #(
  parameter int unsigned chunkWidth = 8
) (
  input  logic [chunkWidth-1:0] A,
  input  logic [chunkWidth-1:0] B,
  input  logic                  CI,
  output logic [chunkWidth-1:0] S,
  output logic                  CO
);

  // Each stage owns its carry signals so the ripple chain is a set of
  // distinct nets rather than one self-referencing vector.
  for (genvar b = 0; b < chunkWidth; b++) begin : g_fa
    logic ci;
    logic co;
    if (b == 0) begin : g_first
      assign ci = CI;
    end else begin : g_next
      assign ci = g_fa[b-1].co;
    end
    FullAdder u_fa (
      .A (A[b]),
      .B (B[b]),
      .CI(ci),
      .S (S[b]),
      .CO(co)
    );
  end

  assign CO = g_fa[chunkWidth-1].co;

endmodule

// File: rtl/mop_cs_accu.sv
// Sequential multi-operand adder. numOps unsigned operands are folded one per
// handshake into a carry-save pair (S, C) through a row of full adders; the
// pair is then resolved into a binary sum chunkWidth bits per cycle and
// offered on a valid/ready result port.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : mop_cs_accu_if.slave (operand in, result out)
module mop_cs_accu
  import mop_cs_accu_pkg::*;
#(
  parameter int unsigned width      = 16,
  parameter int unsigned numOps     = 8,
  parameter int unsigned chunkWidth = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mop_cs_accu_if.slave   bus
);

  localparam int unsigned sumW = sum_width(width, numOps);
  localparam int unsigned K    = num_chunks(sumW, chunkWidth);
  localparam int unsigned cntW = $clog2(numOps) + 1;
  localparam int unsigned idxW = $clog2(K) + 1;

  mop_state_e state;

  logic [sumW-1:0] s_q;
  logic [sumW-1:0] c_q;
  logic [cntW-1:0] cnt_q;
  logic [idxW-1:0] idx_q;
  logic            cy_q;
  logic [sumW-1:0] res_q;
  logic            in_ready_q;
  logic            out_valid_q;

  // ---------------------------------------------------------------------------
  // 3:2 row: S' = S ^ C ^ op, C' = maj(S, C, op) << 1
  // ---------------------------------------------------------------------------
  logic [sumW-1:0] op_ext;
  logic [sumW-1:0] row_s;
  logic [sumW-1:0] row_c;
  logic [sumW-1:0] c_next;

  assign op_ext = sumW'(bus.op_i);

  for (genvar i = 0; i < sumW; i++) begin : g_row
    FullAdder u_fa (
      .A (s_q[i]),
      .B (c_q[i]),
      .CI(op_ext[i]),
      .S (row_s[i]),
      .CO(row_c[i])
    );
  end

  // The top column's carry has weight 2^sumW; the final sum never reaches it,
  // so the pair stays exact modulo 2^sumW. It is masked off rather than left
  // dangling so the row keeps one uniform cell per column.
  assign c_next = {row_c[sumW-2:0], row_c[sumW-1] & 1'b0};

  // ---------------------------------------------------------------------------
  // Chunk select: one-hot on the chunk index, AND-OR per bit. Bits beyond sumW
  // in the last chunk read as zero.
  // ---------------------------------------------------------------------------
  logic [K-1:0]          sel;
  logic [chunkWidth-1:0] chunk_a;
  logic [chunkWidth-1:0] chunk_b;
  logic [chunkWidth-1:0] chunk_sum;
  logic                  chunk_co;
  logic [sumW-1:0]       res_next;

  for (genvar j = 0; j < K; j++) begin : g_sel_dec
    assign sel[j] = (idx_q == idxW'(j));
  end

  for (genvar b = 0; b < chunkWidth; b++) begin : g_sel
    logic [K-1:0] s_col;
    logic [K-1:0] c_col;
    for (genvar j = 0; j < K; j++) begin : g_j
      if (j * chunkWidth + b < sumW) begin : g_live
        assign s_col[j] = sel[j] & s_q[j*chunkWidth+b];
        assign c_col[j] = sel[j] & c_q[j*chunkWidth+b];
      end else begin : g_pad
        assign s_col[j] = 1'b0;
        assign c_col[j] = 1'b0;
      end
    end
    assign chunk_a[b] = |s_col;
    assign chunk_b[b] = |c_col;
  end

  CpaChunk #(
    .chunkWidth(chunkWidth)
  ) u_cpa (
    .A (chunk_a),
    .B (chunk_b),
    .CI(cy_q),
    .S (chunk_sum),
    .CO(chunk_co)
  );

  // Only the selected chunk's result bits take the new value; the truncated
  // tail of the last chunk simply has no destination bit.
  for (genvar p = 0; p < sumW; p++) begin : g_res
    assign res_next[p] = sel[p/chunkWidth] ? chunk_sum[p%chunkWidth] : res_q[p];
  end

  // ---------------------------------------------------------------------------
  // Controller and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ACCU;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        // in_ready_q is high for the whole of ACCU, so valid alone is the
        // handshake here.
        ACCU: begin
          if (bus.in_valid_i) begin
            s_q   <= row_s;
            c_q   <= c_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == cntW'(numOps - 1)) begin
              state      <= RESOLVE;
              idx_q      <= '0;
              cy_q       <= 1'b0;
              in_ready_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          res_q <= res_next;
          cy_q  <= chunk_co;
          idx_q <= idx_q + 1'b1;
          if (idx_q == idxW'(K - 1)) begin
            state       <= OUTPUT;
            out_valid_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.out_ready_i) begin
            state       <= ACCU;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            cy_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ACCU;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.sum_o       = res_q;

endmodule

// File: tb/tb_mop_cs_accu.sv
`timescale 1ns/1ps
module tb_mop_cs_accu;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 10;
  localparam int unsigned LAT = 4;  // handshake cycle to out_valid cycle

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mop_cs_accu_if #(.width(W), .sumW(SW)) bus_if ();

  mop_cs_accu #(
    .width     (W),
    .numOps    (N),
    .chunkWidth(CW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All stimulus changes and samples happen 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [W-1:0] v, output bit ok);
    ok = 1'b0;
    bus_if.in_valid_i = 1'b1;
    bus_if.op_i       = v;
    for (int n = 0; n < 20; n++) begin
      if (bus_if.in_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    bus_if.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(output int cycles, output bit ok);
    cycles = 0;
    while (bus_if.out_valid_o !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
    ok = (bus_if.out_valid_o === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.in_valid_i  = 1'b0;
    bus_if.out_ready_i = 1'b0;
    bus_if.op_i        = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    total++;
    if (bus_if.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", bus_if.in_ready_o);
    end
    total++;
    if (bus_if.out_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", bus_if.out_valid_o);
    end
    total++;
    if (bus_if.sum_o !== '0) begin
      bad++; $display("FAIL reset_sum got=%0d want=0", bus_if.sum_o);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] ops[4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [SW-1:0] exp;
    int cyc;
    bit ok;
    exp_q.push_back(10'd10);
    foreach (ops[i]) begin
      send_op(ops[i], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_send got=timeout want=accept op=%0d", ops[i]); end
    end
    wait_out(cyc, ok);
    total++;
    if (!ok || cyc + 1 != LAT) begin
      bad++; $display("FAIL basic_latency got=%0d (valid=%b) want=%0d", cyc + 1, ok, LAT);
    end
    exp = exp_q.pop_front();
    total++;
    if (bus_if.sum_o !== exp) begin
      bad++; $display("FAIL basic_sum got=%0d want=%0d", bus_if.sum_o, exp);
    end
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
    total++;
    if (bus_if.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL basic_in_ready_after got=%b want=1", bus_if.in_ready_o);
    end
    total++;
    if (bus_if.out_valid_o !== 1'b0) begin
      bad++; $display("FAIL basic_out_valid_after got=%b want=0", bus_if.out_valid_o);
    end
  endtask

  task automatic test_max();
    logic [SW-1:0] exp;
    int cyc;
    bit ok;
    exp_q.push_back(10'h3FC);
    for (int i = 0; i < 4; i++) begin
      send_op(8'd255, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL max_send got=timeout want=accept"); end
    end
    wait_out(cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL max_valid got=timeout want=valid"); end
    exp = exp_q.pop_front();
    total++;
    if (bus_if.sum_o !== exp) begin
      bad++; $display("FAIL max_sum got=%0h want=%0h", bus_if.sum_o, exp);
    end
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ops[4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic [SW-1:0] exp;
    int cyc;
    bit ok;
    exp_q.push_back(10'd100);
    foreach (ops[i]) begin
      send_op(ops[i], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bp_send got=timeout want=accept"); end
    end
    wait_out(cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_valid got=timeout want=valid"); end
    exp = exp_q.pop_front();
    bus_if.op_i = 8'd99;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus_if.sum_o !== exp) begin
        bad++; $display("FAIL bp_sum_stable cyc=%0d got=%0d want=%0d", i, bus_if.sum_o, exp);
      end
      total++;
      if (bus_if.in_ready_o !== 1'b0) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, bus_if.in_ready_o);
      end
      total++;
      if (bus_if.out_valid_o !== 1'b1) begin
        bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, bus_if.out_valid_o);
      end
      bus_if.in_valid_i = (i % 2 == 0);
      tick();
    end
    bus_if.in_valid_i = 1'b0;
    total++;
    if (bus_if.sum_o !== exp) begin
      bad++; $display("FAIL bp_sum_final got=%0d want=%0d", bus_if.sum_o, exp);
    end
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
    total++;
    if (bus_if.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL bp_in_ready_after got=%b want=1", bus_if.in_ready_o);
    end
  endtask

  task automatic test_gaps();
    bit           pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] ops[4] = '{8'd7, 8'd9, 8'd11, 8'd13};
    logic [SW-1:0] exp;
    int k = 0;
    int cyc;
    bit ok;
    exp_q.push_back(10'd40);
    foreach (pat[i]) begin
      total++;
      if (bus_if.in_ready_o !== 1'b1) begin
        bad++; $display("FAIL gaps_in_ready cyc=%0d got=%b want=1", i, bus_if.in_ready_o);
      end
      bus_if.in_valid_i = pat[i];
      if (pat[i]) begin
        bus_if.op_i = ops[k];
        k++;
      end else begin
        bus_if.op_i = 8'hF0;
      end
      tick();
    end
    bus_if.in_valid_i = 1'b0;
    wait_out(cyc, ok);
    total++;
    if (!ok || cyc + 1 != LAT) begin
      bad++; $display("FAIL gaps_latency got=%0d (valid=%b) want=%0d", cyc + 1, ok, LAT);
    end
    exp = exp_q.pop_front();
    total++;
    if (bus_if.sum_o !== exp) begin
      bad++; $display("FAIL gaps_sum got=%0d want=%0d", bus_if.sum_o, exp);
    end
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ops[4] = '{8'd3, 8'd4, 8'd5, 8'd6};
    logic [SW-1:0] exp;
    int cyc;
    bit ok;
    bit seen = 1'b0;
    foreach (ops[i]) begin
      send_op(ops[i], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rmid_send got=timeout want=accept"); end
    end
    tick();  // now resolving chunk 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (bus_if.out_valid_o !== 1'b0) begin
      bad++; $display("FAIL rmid_out_valid got=%b want=0", bus_if.out_valid_o);
    end
    total++;
    if (bus_if.sum_o !== '0) begin
      bad++; $display("FAIL rmid_sum got=%0d want=0", bus_if.sum_o);
    end
    total++;
    if (bus_if.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL rmid_in_ready got=%b want=1", bus_if.in_ready_o);
    end
    repeat (6) begin
      if (bus_if.out_valid_o === 1'b1) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("FAIL rmid_no_output got=valid want=no valid"); end
    exp_q.push_back(10'd20);
    for (int i = 0; i < 4; i++) begin
      send_op(8'd5, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rmid_send2 got=timeout want=accept"); end
    end
    wait_out(cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rmid_valid got=timeout want=valid"); end
    exp = exp_q.pop_front();
    total++;
    if (bus_if.sum_o !== exp) begin
      bad++; $display("FAIL rmid_sum2 got=%0d want=%0d", bus_if.sum_o, exp);
    end
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] grp[2][4] = '{'{8'd100, 8'd50, 8'd25, 8'd0}, '{8'd1, 8'd1, 8'd1, 8'd1}};
    logic [SW-1:0] exp;
    int cyc;
    bit ok;
    exp_q.push_back(10'd175);
    exp_q.push_back(10'd4);
    bus_if.out_ready_i = 1'b1;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        send_op(grp[g][i], ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_send grp=%0d got=timeout want=accept", g); end
      end
      wait_out(cyc, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_valid grp=%0d got=timeout want=valid", g); end
      exp = exp_q.pop_front();
      total++;
      if (bus_if.sum_o !== exp) begin
        bad++; $display("FAIL b2b_sum grp=%0d got=%0d want=%0d", g, bus_if.sum_o, exp);
      end
      tick();
      total++;
      if (bus_if.in_ready_o !== 1'b1) begin
        bad++; $display("FAIL b2b_in_ready grp=%0d got=%b want=1", g, bus_if.in_ready_o);
      end
      total++;
      if (bus_if.out_valid_o !== 1'b0) begin
        bad++; $display("FAIL b2b_out_valid grp=%0d got=%b want=0", g, bus_if.out_valid_o);
      end
    end
    bus_if.out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
